// File: rtl/mul_div_unit_if.sv
// Handshake and operand/result bundle between the core controller and the
// iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit (UMULL, SMULL, UDIV, SDIV).
// Operands are reduced to magnitudes in PREP, one bit is processed per RUN
// cycle, and signs are restored in FIX.
// Optional build macro MDU_EARLY_EXIT_EN: multiplies leave RUN once the
// remaining multiplier bits are zero, and divide-by-zero skips straight from
// PREP to DONE. Results are identical either way.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]          counter;
  logic [1:0]                op_r;
  logic signed [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]          b_mag;
  logic [2*WIDTH-1:0]        acc;
  logic [2*WIDTH-1:0]        mcand;
  logic                      sign_res;
  logic                      rem_sign;
  logic                      dbz_r;

  logic                      is_div;
  logic                      is_signed;
  logic                      a_neg;
  logic                      b_neg;
  logic [WIDTH-1:0]          abs_a;
  logic [WIDTH-1:0]          abs_b;
  logic                      run_last;
  logic                      prep_skip;
  logic                      load_res;

  logic [WIDTH:0]            div_shift;
  logic                      div_ge;
  logic [WIDTH-1:0]          rem_sub;
  logic [WIDTH-1:0]          rem_nxt;

  logic [2*WIDTH-1:0]        prod_fix;
  logic [WIDTH-1:0]          quo_fix;
  logic [WIDTH-1:0]          rem_fix;
  logic [WIDTH-1:0]          fix_lo;
  logic [WIDTH-1:0]          fix_hi;

  logic [WIDTH-1:0]          res_lo;
  logic [WIDTH-1:0]          res_hi;
  logic                      res_dbz;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  assign is_div    = op_r[1];
  assign is_signed = op_r[0];

  // Magnitudes for signed ops; the most-negative value maps to its unsigned
  // magnitude, which fits because the datapath works on unsigned operands.
  assign a_neg = is_signed & a_raw[WIDTH-1];
  assign b_neg = is_signed & b_mag[WIDTH-1];
  assign abs_a = a_neg ? neg_w(a_raw) : a_raw;
  assign abs_b = b_neg ? neg_w(b_mag) : b_mag;

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_mag});
  assign rem_sub   = div_shift[WIDTH-1:0] - b_mag;
  assign rem_nxt   = div_ge ? rem_sub : div_shift[WIDTH-1:0];

`ifdef MDU_EARLY_EXIT_EN
  logic mplr_rest_zero;
  assign mplr_rest_zero = (b_mag[WIDTH-1:1] == '0);
  assign run_last       = (counter == '0) || (!is_div && mplr_rest_zero);
  assign prep_skip      = is_div && dbz_r;
`else
  assign run_last  = (counter == '0);
  assign prep_skip = 1'b0;
`endif

  assign load_res = (state == FIX) || ((state == PREP) && prep_skip);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = prep_skip ? DONE : RUN;
      RUN:     if (run_last) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state)
      PREP, RUN, FIX: bus.busy = 1'b1;
      DONE:           bus.done = 1'b1;
      default:        ;
    endcase
  end

  // Iteration counter: WIDTH-1 down to 0 across RUN.
  always_ff @(posedge clk) begin
    if (reset)                             counter <= '0;
    else if (state == PREP)                counter <= CNT_W'(WIDTH - 1);
    else if (state == RUN && counter != 0) counter <= counter - 1'b1;
  end

  // Operand capture, magnitude prep and one shift-add/shift-subtract per RUN cycle.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          op_r  <= bus.op;
          a_raw <= bus.src_a;
          b_mag <= bus.src_b;
          dbz_r <= bus.op[1] && (bus.src_b == '0);
        end
      end
      PREP: begin
        acc      <= is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
        mcand    <= {{WIDTH{1'b0}}, abs_a};
        b_mag    <= abs_b;
        sign_res <= a_neg ^ b_neg;
        rem_sign <= a_neg;
      end
      RUN: begin
        if (is_div) begin
          acc <= {rem_nxt, acc[WIDTH-2:0], div_ge};
        end else begin
          if (b_mag[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          b_mag <= b_mag >> 1;
        end
      end
      default: ;
    endcase
  end

  // Sign correction and divide-by-zero forcing of the final results.
  always_comb begin
    prod_fix = sign_res ? neg_2w(acc) : acc;
    quo_fix  = sign_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = rem_sign ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    if (is_div && dbz_r) begin
      fix_lo = '1;
      fix_hi = a_raw;
    end else if (is_div) begin
      fix_lo = quo_fix;
      fix_hi = rem_fix;
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Result registers: hold until the next operation completes; a new start
  // clears the divide-by-zero flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_lo  <= '0;
      res_hi  <= '0;
      res_dbz <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      res_dbz <= 1'b0;
    end else if (load_res) begin
      res_lo  <= fix_lo;
      res_hi  <= fix_hi;
      res_dbz <= is_div && dbz_r;
    end
  end

  assign bus.result_lo   = res_lo;
  assign bus.result_hi   = res_hi;
  assign bus.div_by_zero = res_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed bench for mul_div_unit with a transaction-level
// reference model (plain integer arithmetic plus an edge-count latency).
module tb_mul_div_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {div_by_zero, result_hi, result_lo} from plain arithmetic.
  function automatic logic [2*W:0] ref_res(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    p  = '0;
    case (o)
      2'b00: p = {32'd0, a} * {32'd0, b};
      2'b01: p = 64'(longint'(sa) * longint'(sb));
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else p = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return {1'b0, p};
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int ref_lat(input logic [1:0] o, input logic [W-1:0] b);
`ifdef MDU_EARLY_EXIT_EN
    logic [W-1:0] m;
    int runs;
    if (o[1]) return (b == 0) ? 1 : W + 2;
    m = (o[0] && b[W-1]) ? -b : b;
    runs = 1;
    for (int i = 1; i < W; i++) if (m[i]) runs = i + 1;
    return runs + 2;
`else
    if (o == 2'b11 && b == '1) return W + 2;
    return W + 2;
`endif
  endfunction

  // Transaction model state.
  bit           m_init = 0;
  bit           m_active = 0;
  int           m_k = 0;
  int           p_lat = 0;
  logic [2*W:0] p_res;
  logic [W-1:0] e_lo, e_hi;
  logic         e_dz;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1;
      m_active = 0;
      e_lo = '0;
      e_hi = '0;
      e_dz = 1'b0;
    end else if (m_init) begin
      if (!m_active) begin
        if (bus.start) begin
          m_active = 1;
          m_k = 0;
          p_res = ref_res(bus.op, bus.src_a, bus.src_b);
          p_lat = ref_lat(bus.op, bus.src_b);
          e_dz = 1'b0;
        end
      end else begin
        m_k++;
        if (m_k == p_lat) begin
          e_lo = p_res[W-1:0];
          e_hi = p_res[2*W-1:W];
          e_dz = p_res[2*W];
        end else if (m_k > p_lat) begin
          m_active = 0;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      cmp("busy", W'(bus.busy), W'(m_active && m_k < p_lat));
      cmp("done", W'(bus.done), W'(m_active && m_k == p_lat));
      cmp("result_lo", bus.result_lo, e_lo);
      cmp("result_hi", bus.result_hi, e_hi);
      cmp("div_by_zero", W'(bus.div_by_zero), W'(e_dz));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Returns the edge count from the accepting edge to done (first negedge
  // after issue() is the cycle following the accepting edge).
  task automatic wait_done(output int lat);
    bit seen;
    seen = 0;
    lat = -1;
    for (int n = 1; n <= 200 && !seen; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1;
        lat = n - 1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout at %0t: got no done expected done within 200 cycles", $time);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    @(posedge clk);
    @(negedge clk);
    cmp("reset_busy", W'(bus.busy), 32'd0);
    cmp("reset_done", W'(bus.done), 32'd0);
    cmp("reset_lo", bus.result_lo, 32'd0);
    cmp("reset_hi", bus.result_hi, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // UMULL all ones.
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    cmp("umull_lat", 32'(lat), 32'd34);
    cmp("umull_hi", bus.result_hi, 32'hFFFF_FFFE);
    cmp("umull_lo", bus.result_lo, 32'h0000_0001);

    // SMULL -3 * 7.
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat);
    cmp("smull_hi", bus.result_hi, 32'hFFFF_FFFF);
    cmp("smull_lo", bus.result_lo, 32'hFFFF_FFEB);

    // SDIV -7 / 2, then overflow case.
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    cmp("sdiv_q", bus.result_lo, 32'hFFFF_FFFD);
    cmp("sdiv_r", bus.result_hi, 32'hFFFF_FFFF);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    cmp("sdiv_ovf_q", bus.result_lo, 32'h8000_0000);
    cmp("sdiv_ovf_r", bus.result_hi, 32'h0000_0000);
    cmp("sdiv_ovf_dz", W'(bus.div_by_zero), 32'd0);

    // UDIV by zero.
    issue(2'b10, 32'h0000_1234, 32'd0);
    wait_done(lat);
`ifdef MDU_EARLY_EXIT_EN
    cmp("dbz_lat", 32'(lat), 32'd1);
`else
    cmp("dbz_lat", 32'(lat), 32'd34);
`endif
    cmp("dbz_q", bus.result_lo, 32'hFFFF_FFFF);
    cmp("dbz_r", bus.result_hi, 32'h0000_1234);
    cmp("dbz_flag", W'(bus.div_by_zero), 32'd1);

    // Abort by reset, ignored starts while busy, then a clean UDIV 100/7.
    issue(2'b10, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("abort_lo", bus.result_lo, 32'd0);
    cmp("abort_hi", bus.result_hi, 32'd0);
    cmp("abort_busy", W'(bus.busy), 32'd0);
    issue(2'b10, 32'd100, 32'd7);
    repeat (7) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd5; bus.src_b = 32'd6;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(lat);
    cmp("udiv_q", bus.result_lo, 32'd14);
    cmp("udiv_r", bus.result_hi, 32'd2);

    // Back-to-back: first IDLE cycle accepted, done-cycle start ignored.
    issue(2'b00, 32'd3, 32'd5);
    wait_done(lat);
    issue(2'b00, 32'd6, 32'd7);
    @(negedge clk);
    cmp("b2b_busy", W'(bus.busy), 32'd1);
    wait_done(lat);
    cmp("b2b_lo", bus.result_lo, 32'd42);
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd9; bus.src_b = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    cmp("donecyc_busy", W'(bus.busy), 32'd0);
    cmp("donecyc_lo", bus.result_lo, 32'd42);
    repeat (3) @(negedge clk);

    // Randomised operations with occasional ignored starts while busy.
    for (int t = 0; t < 40; t++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb);
      if (ref_lat(ro, rb) > 24 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'($urandom_range(0, 3));
        bus.src_a = $urandom; bus.src_b = $urandom;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end
      wait_done(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
